// File: rtl/gtp_tx_framer_if.sv
// gtp_tx_framer_if: valid/ready payload word stream feeding the GTP TX framer
interface gtp_tx_framer_if;
  logic [15:0] din;
  logic        dvalid;
  logic        dlast;
  logic        dready;
  modport master (output din, dvalid, dlast, input dready);
  modport slave (input din, dvalid, dlast, output dready);
endinterface

// File: rtl/gtp_tx_framer.sv
// gtp_tx_framer: wraps a word stream into SOF/payload/CSUM/EOF frames on a 2-byte 8b10b GTP lane with K28.5 idles
module gtp_tx_framer #(
  parameter int MIN_IDLE  = 4,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk125,
  input  logic              rst_n,
  input  logic              link_ready,
  input  logic [1:0]        chn,
  gtp_tx_framer_if.slave    s,
  output logic [15:0]       txdata,
  output logic [1:0]        txcharisk,
  output logic              frame_done,
  output logic              trunc
);
  localparam int IW = $clog2(MIN_IDLE + 1);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [IW-1:0] IDLE_FULL = IW'(MIN_IDLE);
  localparam logic [IW-1:0] IDLE_LAST = IW'(MIN_IDLE - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_WORDS - 1);
  typedef enum logic [2:0] {S_IDLE, S_SOF, S_DATA, S_CSUM, S_EOF} state_t;
  state_t state, state_nxt;
  logic [7:0] seq;
  logic [15:0] sum, tx_nxt;
  logic [1:0] k_nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idle_cnt;
  logic abort_f, trunc_f, accept;
  assign s.dready = state == S_DATA && link_ready;
  assign accept = s.dready && s.dvalid;
  // the idle leaving IDLE is itself one of the MIN_IDLE gap words
  always_comb begin
    state_nxt = state;
    tx_nxt = 16'h50BC;
    k_nxt = 2'b01;
    case (state)
      S_IDLE: state_nxt = link_ready && s.dvalid && idle_cnt >= IDLE_LAST ? S_SOF : S_IDLE;
      S_SOF: begin
        tx_nxt = {seq, 8'hFB};
        state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_nxt = accept ? s.din : 16'h1C1C;
        k_nxt = accept ? 2'b00 : 2'b11;
        state_nxt = !link_ready || (accept && (s.dlast || cnt == CNT_LAST)) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        tx_nxt = sum;
        k_nxt = 2'b00;
        state_nxt = S_EOF;
      end
      S_EOF: begin
        tx_nxt = {4'b0, chn, abort_f, trunc_f, 8'hFD};
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk125) begin
    if (!rst_n) begin
      state <= S_IDLE;
      txdata <= 16'h50BC;
      txcharisk <= 2'b01;
      frame_done <= 1'b0;
      trunc <= 1'b0;
      seq <= '0;
      sum <= '0;
      cnt <= '0;
      idle_cnt <= IDLE_FULL;
      abort_f <= 1'b0;
      trunc_f <= 1'b0;
    end else begin
      state <= state_nxt;
      txdata <= tx_nxt;
      txcharisk <= k_nxt;
      frame_done <= state == S_EOF;
      trunc <= state == S_EOF && trunc_f;
      if (state == S_IDLE && idle_cnt != IDLE_FULL) idle_cnt <= idle_cnt + 1'b1;
      if (state == S_EOF) begin
        idle_cnt <= '0;
        seq <= seq + 1'b1;
      end
      if (state == S_SOF) begin
        sum <= '0;
        cnt <= '0;
        abort_f <= 1'b0;
        trunc_f <= 1'b0;
      end
      if (accept) begin
        sum <= sum + s.din;
        cnt <= cnt + 1'b1;
        trunc_f <= cnt == CNT_LAST && !s.dlast;
      end
      if (state == S_DATA && !link_ready) abort_f <= 1'b1;
    end
  end
endmodule
